// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller_if
// Brief   : Signal bundle between the pipeline datapath and its hazard control.
// Revision: 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 if_valid;
   logic                 id_uses_rs1;
   logic                 id_uses_rs2;
   logic                 rs1_data_forwarded;
   logic                 rs2_data_forwarded;
   logic [3:0]           rs1;
   logic [3:0]           rs2;
   logic [3:0]           rd_EX;
   logic [3:0]           rd_MEMPREP;
   logic [3:0]           rd_MEMEX;
   logic                 regfile_we_EX;
   logic                 regfile_we_MEMPREP;
   logic                 regfile_we_MEMEX;
   logic                 id_is_drain;
   logic                 branch_taken_EX;
   logic                 lsu_busy;

   logic                 stall_IF;
   logic                 stall_ID;
   logic                 bubble_EX;
   logic                 flush_ID;
   logic                 stall_EX_MEM;
   logic                 bubble_WB;
   logic                 redirect;
   logic                 valid_ID;
   logic                 valid_EX;
   logic                 valid_MEMPREP;
   logic                 valid_MEMEX;
   logic                 valid_WB;
   logic                 mem_timeout_err;
   logic [CNT_WIDTH-1:0] stall_cycles;
   logic [CNT_WIDTH-1:0] flush_count;

   modport master (
      output if_valid, id_uses_rs1, id_uses_rs2, rs1_data_forwarded, rs2_data_forwarded,
             rs1, rs2, rd_EX, rd_MEMPREP, rd_MEMEX,
             regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX,
             id_is_drain, branch_taken_EX, lsu_busy,
      input  stall_IF, stall_ID, bubble_EX, flush_ID, stall_EX_MEM, bubble_WB, redirect,
             valid_ID, valid_EX, valid_MEMPREP, valid_MEMEX, valid_WB,
             mem_timeout_err, stall_cycles, flush_count
   );

   modport slave (
      input  if_valid, id_uses_rs1, id_uses_rs2, rs1_data_forwarded, rs2_data_forwarded,
             rs1, rs2, rd_EX, rd_MEMPREP, rd_MEMEX,
             regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX,
             id_is_drain, branch_taken_EX, lsu_busy,
      output stall_IF, stall_ID, bubble_EX, flush_ID, stall_EX_MEM, bubble_WB, redirect,
             valid_ID, valid_EX, valid_MEMPREP, valid_MEMEX, valid_WB,
             mem_timeout_err, stall_cycles, flush_count
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Brief   : Stall/bubble/flush sequencing and stage valid tracking for the
//           six-stage RV32E pipeline (IF, ID, EX, MEMPREP, MEMEX, WB).
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   pipeline_hazard_controller_if.slave bus
);
   localparam int                  c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_HIT = c_WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_WAIT_W-1:0]  r_wait_cnt;
   logic                 r_timeout_err;
   logic                 r_valid_ID;
   logic                 r_valid_EX;
   logic                 r_valid_MEMPREP;
   logic                 r_valid_MEMEX;
   logic                 r_valid_WB;
   logic [CNT_WIDTH-1:0] r_stall_cycles;
   logic [CNT_WIDTH-1:0] r_flush_count;

   logic w_wr_EX, w_wr_MEMPREP, w_wr_MEMEX;
   logic w_rs1_hit, w_rs2_hit;
   logic w_hazard, w_back_busy, w_drain_req;
   logic w_mem_stall, w_branch, w_id_stall, w_stall_IF;

   // Only a valid producer with its write enable set can create a dependency.
   assign w_wr_EX      = r_valid_EX      & bus.regfile_we_EX;
   assign w_wr_MEMPREP = r_valid_MEMPREP & bus.regfile_we_MEMPREP;
   assign w_wr_MEMEX   = r_valid_MEMEX   & bus.regfile_we_MEMEX;

   assign w_rs1_hit = bus.id_uses_rs1 && (bus.rs1 != 4'd0) && !bus.rs1_data_forwarded &&
                      ((w_wr_EX      && (bus.rs1 == bus.rd_EX))      ||
                       (w_wr_MEMPREP && (bus.rs1 == bus.rd_MEMPREP)) ||
                       (w_wr_MEMEX   && (bus.rs1 == bus.rd_MEMEX)));
   assign w_rs2_hit = bus.id_uses_rs2 && (bus.rs2 != 4'd0) && !bus.rs2_data_forwarded &&
                      ((w_wr_EX      && (bus.rs2 == bus.rd_EX))      ||
                       (w_wr_MEMPREP && (bus.rs2 == bus.rd_MEMPREP)) ||
                       (w_wr_MEMEX   && (bus.rs2 == bus.rd_MEMEX)));

   assign w_hazard    = r_valid_ID & (w_rs1_hit | w_rs2_hit);
   assign w_back_busy = r_valid_EX | r_valid_MEMPREP | r_valid_MEMEX | r_valid_WB;
   assign w_drain_req = r_valid_ID & bus.id_is_drain & w_back_busy;

   assign w_mem_stall = r_valid_MEMEX & bus.lsu_busy;
   assign w_branch    = r_valid_EX & bus.branch_taken_EX & ~w_mem_stall;
   assign w_id_stall  = (w_hazard | w_drain_req) & ~w_branch & ~w_mem_stall;
   assign w_stall_IF  = w_mem_stall | w_id_stall;

   assign bus.stall_IF        = w_stall_IF;
   assign bus.stall_ID        = w_stall_IF;
   assign bus.bubble_EX       = w_branch | w_id_stall;
   assign bus.flush_ID        = w_branch;
   assign bus.stall_EX_MEM    = w_mem_stall;
   assign bus.bubble_WB       = w_mem_stall;
   assign bus.redirect        = w_branch;
   assign bus.valid_ID        = r_valid_ID;
   assign bus.valid_EX        = r_valid_EX;
   assign bus.valid_MEMPREP   = r_valid_MEMPREP;
   assign bus.valid_MEMEX     = r_valid_MEMEX;
   assign bus.valid_WB        = r_valid_WB;
   assign bus.mem_timeout_err = r_timeout_err;
   assign bus.stall_cycles    = r_stall_cycles;
   assign bus.flush_count     = r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_stall)
                  r_state <= ST_MEM_WAIT;
               else if (w_drain_req && !w_branch)
                  r_state <= ST_DRAIN;
            end
            ST_MEM_WAIT: begin
               if (!bus.lsu_busy)
                  r_state <= ST_RUN;
            end
            ST_DRAIN: begin
               if (w_mem_stall)
                  r_state <= ST_MEM_WAIT;
               else if (!w_back_busy)
                  r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase

         // Wait counter saturates; the error latches on the cycle it hits the limit.
         if (r_state == ST_MEM_WAIT && bus.lsu_busy) begin
            if (r_wait_cnt != c_WAIT_MAX)
               r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            if (r_wait_cnt == c_WAIT_HIT)
               r_timeout_err <= 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_ID      <= 1'b0;
         r_valid_EX      <= 1'b0;
         r_valid_MEMPREP <= 1'b0;
         r_valid_MEMEX   <= 1'b0;
         r_valid_WB      <= 1'b0;
         r_stall_cycles  <= '0;
         r_flush_count   <= '0;
      end else begin
         if (w_mem_stall) begin
            r_valid_WB <= 1'b0;
         end else begin
            r_valid_WB      <= r_valid_MEMEX;
            r_valid_MEMEX   <= r_valid_MEMPREP;
            r_valid_MEMPREP <= r_valid_EX;
            if (w_branch) begin
               r_valid_EX <= 1'b0;
               r_valid_ID <= 1'b0;
            end else if (w_id_stall) begin
               r_valid_EX <= 1'b0;
            end else begin
               r_valid_EX <= r_valid_ID;
               r_valid_ID <= bus.if_valid;
            end
         end
         if (w_stall_IF)
            r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
         if (w_branch)
            r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_controller
// Brief   : Directed scenarios plus random traffic against a stage-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;
   localparam int CW  = 8;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipeline_hazard_controller_if #(.CNT_WIDTH(CW)) bus ();

   pipeline_hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Model: m_v[0..4] = ID, EX, MEMPREP, MEMEX, WB
   bit          m_v [5];
   logic [CW-1:0] m_stall;
   logic [CW-1:0] m_flush;
   int          m_streak;
   bit          m_err;
   int          n_cmp;
   int          n_fail;

   task automatic model_reset();
      for (int s = 0; s < 5; s++) m_v[s] = 1'b0;
      m_stall  = '0;
      m_flush  = '0;
      m_streak = 0;
      m_err    = 1'b0;
   endtask

   function automatic bit blocked(input bit uses, input bit fwd, input logic [3:0] rs);
      logic [3:0] rd [3];
      bit         we [3];
      rd[0] = bus.rd_EX;  rd[1] = bus.rd_MEMPREP;  rd[2] = bus.rd_MEMEX;
      we[0] = bus.regfile_we_EX;  we[1] = bus.regfile_we_MEMPREP;  we[2] = bus.regfile_we_MEMEX;
      blocked = 1'b0;
      if (uses && !fwd && rs != 4'd0)
         for (int s = 0; s < 3; s++)
            if (m_v[s+1] && we[s] && rd[s] == rs) blocked = 1'b1;
   endfunction

   function automatic logic [12:0] obs_vec();
      obs_vec = {bus.stall_IF, bus.stall_ID, bus.bubble_EX, bus.flush_ID, bus.stall_EX_MEM,
                 bus.bubble_WB, bus.redirect, bus.valid_ID, bus.valid_EX, bus.valid_MEMPREP,
                 bus.valid_MEMEX, bus.valid_WB, bus.mem_timeout_err};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.if_valid = 1'b0;  bus.id_uses_rs1 = 1'b0;  bus.id_uses_rs2 = 1'b0;
      bus.rs1_data_forwarded = 1'b0;  bus.rs2_data_forwarded = 1'b0;
      bus.rs1 = 4'd0;  bus.rs2 = 4'd0;
      bus.rd_EX = 4'd0;  bus.rd_MEMPREP = 4'd0;  bus.rd_MEMEX = 4'd0;
      bus.regfile_we_EX = 1'b0;  bus.regfile_we_MEMPREP = 1'b0;  bus.regfile_we_MEMEX = 1'b0;
      bus.id_is_drain = 1'b0;  bus.branch_taken_EX = 1'b0;  bus.lsu_busy = 1'b0;
   endtask

   // Called at a negedge with inputs set; checks, crosses one posedge, returns at next negedge.
   task automatic step(input string tag);
      bit mem, br, idst, haz, drn;
      int b;
      logic [12:0] exp;
      #2;
      mem = 1'b0;  br = 1'b0;  idst = 1'b0;
      if (rst_n) begin
         haz  = m_v[0] && (blocked(bus.id_uses_rs1, bus.rs1_data_forwarded, bus.rs1) ||
                           blocked(bus.id_uses_rs2, bus.rs2_data_forwarded, bus.rs2));
         drn  = m_v[0] && bus.id_is_drain && (m_v[1] || m_v[2] || m_v[3] || m_v[4]);
         mem  = m_v[3] && bus.lsu_busy;
         br   = !mem && m_v[1] && bus.branch_taken_EX;
         idst = !mem && !br && (haz || drn);
      end
      exp = {mem | idst, mem | idst, br | idst, br, mem, mem, br,
             m_v[0], m_v[1], m_v[2], m_v[3], m_v[4], m_err};
      check({tag, ".ctl"}, 32'(obs_vec()), 32'(exp));
      check({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(m_stall));
      check({tag, ".flush_count"}, 32'(bus.flush_count), 32'(m_flush));
      @(posedge clk);
      if (rst_n) begin
         // b = first stage loaded with a bubble (or with if_valid when b==0); below it holds.
         b = mem ? 4 : ((br || idst) ? 1 : 0);
         for (int s = 4; s > b; s--) m_v[s] = m_v[s-1];
         m_v[b] = (b == 0) ? bit'(bus.if_valid) : 1'b0;
         if (br) m_v[0] = 1'b0;
         if (mem || idst) m_stall = m_stall + 1'b1;
         if (br) m_flush = m_flush + 1'b1;
         m_streak = mem ? m_streak + 1 : 0;
         if (m_streak > TMO) m_err = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      model_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      step("reset0");
      step("reset1");
      rst_n = 1'b1;

      // Load into EX writing x5, consumer in ID reading x5 without forwarding.
      bus.if_valid = 1'b1;
      step("ld_fill0");
      step("ld_fill1");
      bus.if_valid = 1'b0;
      bus.id_uses_rs1 = 1'b1;  bus.rs1 = 4'd5;
      bus.rd_EX = 4'd5;  bus.rd_MEMPREP = 4'd5;  bus.rd_MEMEX = 4'd5;
      bus.regfile_we_EX = 1'b1;  bus.regfile_we_MEMPREP = 1'b1;  bus.regfile_we_MEMEX = 1'b1;
      for (int i = 0; i < 4; i++) step("ld_use");
      check("ld_use.stall_total", 32'(bus.stall_cycles), 32'd3);
      check("ld_use.consumer_in_EX", 32'(bus.valid_EX), 32'd1);

      // Taken branch in EX with a valid ID.
      idle();
      for (int i = 0; i < 4; i++) step("br_empty");
      bus.if_valid = 1'b1;
      step("br_fill0");
      step("br_fill1");
      bus.branch_taken_EX = 1'b1;
      step("br_taken");
      bus.branch_taken_EX = 1'b0;
      check("br.valid_ID_cleared", 32'(bus.valid_ID), 32'd0);
      check("br.flush_count", 32'(bus.flush_count), 32'd1);
      check("br.branch_in_MEMPREP", 32'(bus.valid_MEMPREP), 32'd1);

      // LSU busy for four cycles with a taken branch waiting in EX.
      for (int i = 0; i < 4; i++) step("mb_fill");
      bus.if_valid = 1'b0;
      bus.branch_taken_EX = 1'b1;
      bus.lsu_busy = 1'b1;
      for (int i = 0; i < 4; i++) step("mb_hold");
      bus.lsu_busy = 1'b0;
      step("mb_release");
      bus.branch_taken_EX = 1'b0;
      check("mb.flush_count", 32'(bus.flush_count), 32'd2);

      // FENCE/ECALL in ID behind a full pipe.
      bus.if_valid = 1'b1;
      for (int i = 0; i < 5; i++) step("dr_fill");
      bus.if_valid = 1'b0;
      bus.id_is_drain = 1'b1;
      for (int i = 0; i < 5; i++) step("drain");
      bus.id_is_drain = 1'b0;
      check("drain.instr_in_EX", 32'(bus.valid_EX), 32'd1);
      check("drain.ID_empty", 32'(bus.valid_ID), 32'd0);

      // Memory timeout.
      for (int i = 0; i < 5; i++) step("to_empty");
      bus.if_valid = 1'b1;
      for (int i = 0; i < 4; i++) step("to_fill");
      bus.if_valid = 1'b0;
      bus.lsu_busy = 1'b1;
      for (int i = 0; i < 8; i++) step("to_busy");
      check("timeout.not_yet", 32'(bus.mem_timeout_err), 32'd0);
      step("to_busy9");
      check("timeout.set", 32'(bus.mem_timeout_err), 32'd1);
      for (int i = 0; i < 11; i++) step("to_busy_more");
      bus.lsu_busy = 1'b0;
      for (int i = 0; i < 3; i++) step("to_after");
      check("timeout.sticky", 32'(bus.mem_timeout_err), 32'd1);

      // Reset pulse in the middle of a hazard stall.
      bus.if_valid = 1'b1;
      step("rs_fill0");
      step("rs_fill1");
      bus.if_valid = 1'b0;
      bus.id_uses_rs2 = 1'b1;  bus.rs2 = 4'd7;
      bus.rd_EX = 4'd7;  bus.regfile_we_EX = 1'b1;
      step("rs_stall");
      #2 rst_n = 1'b0;
      #1;
      check("rst_async.ctl", 32'(obs_vec()), 32'd0);
      check("rst_async.counters", 32'({bus.stall_cycles, bus.flush_count}), 32'd0);
      model_reset();
      @(negedge clk);
      step("rs_low");
      rst_n = 1'b1;
      idle();
      bus.if_valid = 1'b1;
      for (int i = 0; i < 5; i++) step("rs_refill");

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bus.if_valid           = ($urandom_range(0, 99) < 80);
         bus.id_uses_rs1        = ($urandom_range(0, 99) < 60);
         bus.id_uses_rs2        = ($urandom_range(0, 99) < 40);
         bus.rs1_data_forwarded = ($urandom_range(0, 99) < 30);
         bus.rs2_data_forwarded = ($urandom_range(0, 99) < 30);
         bus.rs1                = 4'($urandom_range(0, 3));
         bus.rs2                = 4'($urandom_range(0, 3));
         bus.rd_EX              = 4'($urandom_range(0, 3));
         bus.rd_MEMPREP         = 4'($urandom_range(0, 3));
         bus.rd_MEMEX           = 4'($urandom_range(0, 3));
         bus.regfile_we_EX      = ($urandom_range(0, 99) < 60);
         bus.regfile_we_MEMPREP = ($urandom_range(0, 99) < 60);
         bus.regfile_we_MEMEX   = ($urandom_range(0, 99) < 60);
         bus.id_is_drain        = ($urandom_range(0, 99) < 8);
         bus.branch_taken_EX    = ($urandom_range(0, 99) < 15);
         bus.lsu_busy           = ($urandom_range(0, 99) < 30);
         step("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
